mem_arbiter: RTL and testbench

- Arbitrates and sequences access to the single-port `memory` block between two requesters:
  - port 0: the CPU `controller` path;
  - port 1: a secondary master, e.g. a program loader or DMA.
- Converts each granted request into the memory's addr_en → in_en/out_en strobe sequence, then returns an ack pulse and read data to the winning port.
- Uses round-robin arbitration on ties; one transaction is in flight at a time.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port memory block.
// Port 0 is the CPU controller path, port 1 a secondary master (loader/DMA).
// Each granted request becomes an addr_en -> in_en/out_en strobe sequence,
// followed by a one-cycle ack (and read data) back to the winning port.
//
// Handshake: a port raises req (level) with we/addr/wdata stable and keeps
// it high until it sees its one-cycle ack. req is only sampled while the
// arbiter is idle, so dropping it after the grant does not abort anything.
// A port whose ack was high in the previous cycle is not eligible, which
// gives the requester one cycle to drop req before it could be re-granted.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int READ_WAIT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_addr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_in_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_out_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] RW_LAST = 3'(READ_WAIT);

  state_t                state;
  logic                  owner;       // 0: port 0, 1: port 1
  logic                  last_owner;  // owner of the most recent completed transfer
  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [2:0]            wait_cnt;
  logic                  ack0_q;
  logic                  ack1_q;

  logic elig0;
  logic elig1;
  logic win;

  // Eligibility excludes a port that was acked last cycle; ties go to the
  // port that did not own the previous transfer.
  assign elig0 = m0_req & ~ack0_q;
  assign elig1 = m1_req & ~ack1_q;
  assign win   = (elig0 & elig1) ? ~last_owner : elig1;

  // Transaction sequencer: arbitration, strobe generation, ack and read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      lat_we      <= 1'b0;
      lat_wdata   <= '0;
      wait_cnt    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      m0_gnt      <= 1'b0;
      m0_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_gnt      <= 1'b0;
      m1_ack      <= 1'b0;
      m1_rdata    <= '0;
      mem_addr_en <= 1'b0;
      mem_addr    <= '0;
      mem_in_en   <= 1'b0;
      mem_wdata   <= '0;
      mem_out_en  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ack0_q <= m0_ack;
      ack1_q <= m1_ack;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            owner       <= win;
            lat_we      <= win ? m1_we : m0_we;
            lat_wdata   <= win ? m1_wdata : m0_wdata;
            mem_addr    <= win ? m1_addr : m0_addr;
            mem_addr_en <= 1'b1;
            m0_gnt      <= ~win;
            m1_gnt      <= win;
            busy        <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          mem_addr_en <= 1'b0;
          if (lat_we) begin
            mem_in_en <= 1'b1;
            mem_wdata <= lat_wdata;
          end else begin
            mem_out_en <= 1'b1;
            wait_cnt   <= '0;
          end
          state <= DATA;
        end
        DATA: begin
          if (lat_we) begin
            mem_in_en <= 1'b0;
            m0_ack    <= ~owner;
            m1_ack    <= owner;
            state     <= DONE;
          end else if (wait_cnt == RW_LAST) begin
            mem_out_en <= 1'b0;
            if (owner) m1_rdata <= mem_rdata;
            else       m0_rdata <= mem_rdata;
            m0_ack     <= ~owner;
            m1_ack     <= owner;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        DONE: begin
          last_owner <= owner;
          m0_gnt     <= 1'b0;
          m1_gnt     <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (READ_WAIT=0 and READ_WAIT=2), each
// with its own memory, requesters and transaction-offset reference model.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int N  = 2;   // instance k uses READ_WAIT = 2*k

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req   [N][2];
  logic          we    [N][2];
  logic [AW-1:0] addr  [N][2];
  logic [DW-1:0] wdata [N][2];
  logic          gnt   [N][2];
  logic          ack   [N][2];
  logic [DW-1:0] rdata [N][2];
  logic          mae [N];
  logic          mie [N];
  logic          moe [N];
  logic          bsy [N];
  logic [AW-1:0] ma  [N];
  logic [DW-1:0] mwd [N];
  logic [DW-1:0] mrd [N];

  // environment memories (behave like the memory block)
  logic [DW-1:0] env_mem [N][65536];
  logic [AW-1:0] env_lat [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_WAIT(2*g)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
      .m0_gnt(gnt[g][0]), .m0_ack(ack[g][0]), .m0_rdata(rdata[g][0]),
      .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
      .m1_gnt(gnt[g][1]), .m1_ack(ack[g][1]), .m1_rdata(rdata[g][1]),
      .mem_addr_en(mae[g]), .mem_addr(ma[g]), .mem_in_en(mie[g]), .mem_wdata(mwd[g]),
      .mem_out_en(moe[g]), .mem_rdata(mrd[g]), .busy(bsy[g])
    );
    assign mrd[g] = env_mem[g][env_lat[g]];
    always @(posedge clk) begin
      if (mae[g]) env_lat[g] <= ma[g];
      if (mie[g]) env_mem[g][env_lat[g]] <= mwd[g];
    end
  end

  // ---------------- reference model ----------------
  // A transaction is tracked by its offset t from the grant edge:
  // t=1 address strobe, t=2.. data strobes, ack at t=3 (write) or 3+READ_WAIT (read).
  bit            fly_m  [N];
  int            t_m    [N];
  bit            own_m  [N];
  bit            we_m   [N];
  logic [AW-1:0] a_m    [N];
  logic [DW-1:0] wd_m   [N];
  bit            last_m [N];
  bit            ackp_m [N][2];
  logic [DW-1:0] mem_m  [N][65536];
  logic          e_mae [N];
  logic          e_mie [N];
  logic          e_moe [N];
  logic          e_busy[N];
  logic [AW-1:0] e_ma  [N];
  logic [DW-1:0] e_mwd [N];
  logic          e_gnt [N][2];
  logic          e_ack [N][2];
  logic [DW-1:0] e_rd  [N][2];

  // scoreboard: {we, owner, data} of every predicted completion
  logic [DW+1:0] exp_q0[$];
  logic [DW+1:0] exp_q1[$];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int rw;
    int doff;
    bit pa0, pa1, e0, e1, o;
    rw = 2 * k;
    if (rst) begin
      fly_m[k] = 0; t_m[k] = 0; last_m[k] = 1; own_m[k] = 0; we_m[k] = 0;
      ackp_m[k][0] = 0; ackp_m[k][1] = 0;
      e_mae[k] = 0; e_mie[k] = 0; e_moe[k] = 0; e_busy[k] = 0;
      e_ma[k] = '0; e_mwd[k] = '0;
      for (int p = 0; p < 2; p++) begin
        e_gnt[k][p] = 0; e_ack[k][p] = 0; e_rd[k][p] = '0;
      end
      if (k == 0) exp_q0.delete(); else exp_q1.delete();
      return;
    end
    pa0 = ackp_m[k][0];
    pa1 = ackp_m[k][1];
    ackp_m[k][0] = e_ack[k][0];
    ackp_m[k][1] = e_ack[k][1];
    if (fly_m[k]) begin
      doff = we_m[k] ? 3 : 3 + rw;
      if (t_m[k] == doff) begin fly_m[k] = 0; t_m[k] = 0; end
      else t_m[k]++;
    end else begin
      e0 = req[k][0] && !pa0;
      e1 = req[k][1] && !pa1;
      if (e0 || e1) begin
        o = (e0 && e1) ? !last_m[k] : e1;
        own_m[k] = o; we_m[k] = we[k][o]; a_m[k] = addr[k][o]; wd_m[k] = wdata[k][o];
        fly_m[k] = 1; t_m[k] = 1;
      end
    end
    doff = we_m[k] ? 3 : 3 + rw;
    e_busy[k] = fly_m[k];
    e_mae[k]  = fly_m[k] && t_m[k] == 1;
    e_mie[k]  = fly_m[k] && we_m[k] && t_m[k] == 2;
    e_moe[k]  = fly_m[k] && !we_m[k] && t_m[k] >= 2 && t_m[k] <= 2 + rw;
    for (int p = 0; p < 2; p++) begin
      e_gnt[k][p] = fly_m[k] && own_m[k] == p[0];
      e_ack[k][p] = fly_m[k] && own_m[k] == p[0] && t_m[k] == doff;
    end
    if (e_mae[k]) e_ma[k] = a_m[k];
    if (e_mie[k]) begin
      e_mwd[k] = wd_m[k];
      mem_m[k][a_m[k]] = wd_m[k];
    end
    if (fly_m[k] && t_m[k] == doff) begin
      if (!we_m[k]) e_rd[k][own_m[k]] = mem_m[k][a_m[k]];
      last_m[k] = own_m[k];
      if (k == 0) exp_q0.push_back({we_m[k], own_m[k], we_m[k] ? wd_m[k] : mem_m[k][a_m[k]]});
      else        exp_q1.push_back({we_m[k], own_m[k], we_m[k] ? wd_m[k] : mem_m[k][a_m[k]]});
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) model_step(k);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        check("strobes_busy", k, {28'd0, mae[k], mie[k], moe[k], bsy[k]},
              {28'd0, e_mae[k], e_mie[k], e_moe[k], e_busy[k]});
        check("gnt_ack", k, {28'd0, gnt[k][0], gnt[k][1], ack[k][0], ack[k][1]},
              {28'd0, e_gnt[k][0], e_gnt[k][1], e_ack[k][0], e_ack[k][1]});
        check("strobe_excl", k, 32'(int'(mae[k]) + int'(mie[k]) + int'(moe[k]) <= 1), 32'd1);
        check("mem_addr", k, 32'(ma[k]), 32'(e_ma[k]));
        check("mem_wdata", k, 32'(mwd[k]), 32'(e_mwd[k]));
        check("m0_rdata", k, 32'(rdata[k][0]), 32'(e_rd[k][0]));
        check("m1_rdata", k, 32'(rdata[k][1]), 32'(e_rd[k][1]));
        for (int p = 0; p < 2; p++) begin
          if (ack[k][p] === 1'b1) begin
            logic [DW+1:0] e;
            if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
              n_checks++; n_errors++;
              $display("FAIL sb_unexpected_ack dut%0d port%0d t=%0t got=ack expected=none", k, p, $time);
            end else begin
              e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check("sb_owner", k, 32'(p), 32'(e[DW]));
              if (!e[DW+1]) check("sb_rdata", k, 32'(rdata[k][p]), 32'(e[DW-1:0]));
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int k, input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k][p] = r; we[k][p] = w; addr[k][p] = a; wdata[k][p] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 2; p++) set_port(k, p, 1'b0, 1'b0, '0, '0);
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_ack(input int k, input int p);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack[k][p] === 1'b1) return;
    end
    n_checks++; n_errors++;
    $display("FAIL ack_timeout dut%0d port%0d t=%0t got=no_ack expected=ack", k, p, $time);
  endtask

  task automatic port_proc(input int k, input int p, input int n);
    int g;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = AW'($urandom);
      set_port(k, p, 1'b1, 1'($urandom_range(0, 1)), a, DW'($urandom));
      wait_ack(k, p);
      step();
      g = $urandom_range(0, 2);
      if (g != 0) begin
        req[k][p] = 1'b0;
        repeat (g) step();
      end
    end
    req[k][p] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, ack_c, nr;
    int ord [4];
    logic pg0, pg1;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      env_lat[k] = '0;
      for (int a = 0; a < 65536; a++) begin
        env_mem[k][a] = 16'(a) ^ 16'h5A5A;
        mem_m[k][a]   = 16'(a) ^ 16'h5A5A;
      end
      for (int p = 0; p < 2; p++) set_port(k, p, 1'b0, 1'b0, '0, '0);
    end
    step();
    chk_en = 1'b1;
    do_reset();
    check("reset_busy", 0, 32'(bsy[0]), 32'd0);
    check("reset_rdata", 0, 32'(rdata[0][0]), 32'd0);

    // port 0 write 0x0010 <- 0xBEEF on instance 0
    set_port(0, 0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);                                     // cycle 0
    check("wr_c0_addr_en", 0, 32'(mae[0]), 32'd0);
    @(negedge clk);                                     // cycle 1
    check("wr_c1_addr_en", 0, 32'(mae[0]), 32'd1);
    check("wr_c1_mem_addr", 0, 32'(ma[0]), 32'h0010);
    @(negedge clk);                                     // cycle 2
    check("wr_c2_in_en", 0, 32'(mie[0]), 32'd1);
    check("wr_c2_wdata", 0, 32'(mwd[0]), 32'hBEEF);
    @(negedge clk);                                     // cycle 3
    check("wr_c3_ack", 0, 32'(ack[0][0]), 32'd1);
    step();
    req[0][0] = 1'b0;
    @(negedge clk);
    check("wr_c4_ack", 0, 32'(ack[0][0]), 32'd0);
    step();

    // port 0 read-back of 0x0010
    set_port(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    repeat (4) @(negedge clk);                          // cycle 3
    check("rd_ack", 0, 32'(ack[0][0]), 32'd1);
    check("rd_rdata", 0, 32'(rdata[0][0]), 32'hBEEF);
    step();
    req[0][0] = 1'b0;
    @(negedge clk);
    check("rd_rdata_hold", 0, 32'(rdata[0][0]), 32'hBEEF);
    check("rd_m1_rdata", 0, 32'(rdata[0][1]), 32'h0000);
    step();

    // simultaneous requests after reset: 0, then 1, next tie 0
    do_reset();
    set_port(0, 0, 1'b1, 1'b1, 16'h0100, 16'h1111);
    set_port(0, 1, 1'b1, 1'b1, 16'h0101, 16'h2222);
    repeat (2) @(negedge clk);
    check("tie1_gnt", 0, {30'd0, gnt[0][0], gnt[0][1]}, 32'b10);
    wait_ack(0, 0);
    step();
    req[0][0] = 1'b0;
    repeat (2) @(negedge clk);
    check("tie1_second_gnt", 0, {30'd0, gnt[0][0], gnt[0][1]}, 32'b01);
    wait_ack(0, 1);
    step();
    req[0][1] = 1'b0;
    step();
    req[0][0] = 1'b1;
    req[0][1] = 1'b1;
    repeat (2) @(negedge clk);
    check("tie2_gnt", 0, {30'd0, gnt[0][0], gnt[0][1]}, 32'b10);
    wait_ack(0, 0);
    step();
    req[0][0] = 1'b0;
    wait_ack(0, 1);
    step();
    req[0][1] = 1'b0;
    step();

    // both requests held: grants alternate 0,1,0,1
    do_reset();
    set_port(0, 0, 1'b1, 1'b1, 16'h0200, 16'h3333);
    set_port(0, 1, 1'b1, 1'b1, 16'h0201, 16'h4444);
    for (int i = 0; i < 4; i++) ord[i] = -1;
    nr = 0; pg0 = 1'b0; pg1 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gnt[0][0] && !pg0 && nr < 4) begin ord[nr] = 0; nr++; end
      if (gnt[0][1] && !pg1 && nr < 4) begin ord[nr] = 1; nr++; end
      pg0 = gnt[0][0]; pg1 = gnt[0][1];
    end
    step();
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    for (int i = 0; i < 4; i++) check("alt_order", 0, 32'(ord[i]), 32'(i % 2));
    repeat (5) step();

    // READ_WAIT=2 instance, port 1 read of 0x0020
    set_port(1, 1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    cnt = 0; ack_c = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (moe[1]) cnt++;
      if (ack[1][1] && ack_c < 0) begin
        ack_c = c;
        check("rw2_rdata", 1, 32'(rdata[1][1]), 32'h5A7A);
        req[1][1] = 1'b0;
      end
    end
    check("rw2_out_en_cycles", 1, 32'(cnt), 32'd3);
    check("rw2_ack_cycle", 1, 32'(ack_c), 32'd5);
    step();

    // reset during the DATA cycle of a write
    do_reset();
    set_port(0, 0, 1'b1, 1'b1, 16'h0033, 16'h1234);
    repeat (3) @(negedge clk);                          // cycle 2
    check("rst_mid_in_en", 0, 32'(mie[0]), 32'd1);
    rst = 1'b1;
    req[0][0] = 1'b0;
    @(negedge clk);                                     // cycle 3
    check("rst_mid_outputs", 0,
          {24'd0, bsy[0], ack[0][0], gnt[0][0], mie[0], mae[0], moe[0], 2'b00}, 32'd0);
    check("rst_mid_wdata", 0, 32'(mwd[0]), 32'd0);
    step();
    rst = 1'b0;
    step();
    set_port(0, 0, 1'b1, 1'b0, 16'h0033, 16'h0000);
    set_port(0, 1, 1'b1, 1'b0, 16'h0034, 16'h0000);
    repeat (2) @(negedge clk);
    check("rst_tie_gnt", 0, {30'd0, gnt[0][0], gnt[0][1]}, 32'b10);
    wait_ack(0, 0);
    step();
    req[0][0] = 1'b0;
    wait_ack(0, 1);
    step();
    req[0][1] = 1'b0;
    step();

    // randomized traffic on both instances
    fork
      port_proc(0, 0, 60);
      port_proc(0, 1, 60);
      port_proc(1, 0, 60);
      port_proc(1, 1, 60);
    join
    repeat (12) step();
    check("sb_drain", 0, 32'(exp_q0.size()), 32'd0);
    check("sb_drain", 1, 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t got=running expected=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
